// File: rtl/apb2ahb_bridge.sv
// APB3/APB4 completer to AHB-Lite manager bridge: each APB access becomes one AHB SINGLE transfer.
// Non-pipelined; PREADY stretches the APB access phase until the AHB data phase finishes.
module apb2ahb_bridge #(
   parameter int ADDRWIDTH = 16,
   parameter int DATAWIDTH = 32
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic                 PSEL,
   input  logic                 PENABLE,
   input  logic [ADDRWIDTH-1:0] PADDR,
   input  logic                 PWRITE,
   input  logic [DATAWIDTH-1:0] PWDATA,
   input  logic [3:0]           PSTRB,
   input  logic [2:0]           PPROT,
   output logic [DATAWIDTH-1:0] PRDATA,
   output logic                 PREADY,
   output logic                 PSLVERR,
   output logic [ADDRWIDTH-1:0] HADDR,
   output logic [1:0]           HTRANS,
   output logic                 HWRITE,
   output logic [2:0]           HSIZE,
   output logic [2:0]           HBURST,
   output logic [3:0]           HPROT,
   output logic                 HMASTLOCK,
   output logic [DATAWIDTH-1:0] HWDATA,
   input  logic [DATAWIDTH-1:0] HRDATA,
   input  logic                 HREADY,
   input  logic                 HRESP,
   output logic                 APBACTIVE
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ADDR = 2'b01,
      DATA = 2'b10,
      DONE = 2'b11
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   // Returns {legal, hsize[2:0], haddr_lsb[1:0]} for a non-zero write strobe.
   function automatic logic [5:0] strb_decode(input logic [3:0] strb);
      logic [5:0] res;
      case (strb)
         4'b1111: res = {1'b1, 3'b010, 2'b00};
         4'b0011: res = {1'b1, 3'b001, 2'b00};
         4'b1100: res = {1'b1, 3'b001, 2'b10};
         4'b0001: res = {1'b1, 3'b000, 2'b00};
         4'b0010: res = {1'b1, 3'b000, 2'b01};
         4'b0100: res = {1'b1, 3'b000, 2'b10};
         4'b1000: res = {1'b1, 3'b000, 2'b11};
         default: res = {1'b0, 3'b010, 2'b00};
      endcase
      return res;
   endfunction

   state_t                 state_r, state_s;
   logic [DATAWIDTH-1:0]   prdata_r, prdata_s;
   logic                   pready_r, pready_s;
   logic                   pslverr_r, pslverr_s;
   logic [ADDRWIDTH-1:0]   haddr_r, haddr_s;
   logic [1:0]             htrans_r, htrans_s;
   logic                   hwrite_r, hwrite_s;
   logic [2:0]             hsize_r, hsize_s;
   logic [3:0]             hprot_r, hprot_s;
   logic [DATAWIDTH-1:0]   hwdata_r, hwdata_s;
   logic [DATAWIDTH-1:0]   wdata_r, wdata_s;
   logic                   abort_r, abort_s;
   logic                   apbactive_r;
   logic [5:0]             strb_dec_s;
   logic [3:0]             hprot_map_s;
   logic                   unused_s;

   assign strb_dec_s  = strb_decode(PSTRB);
   assign hprot_map_s = {2'b00, PPROT[0], ~PPROT[2]};
   // Address LSBs come from the strobe decode, and PPROT[1] has no AHB counterpart.
   assign unused_s    = ^{PPROT[1], PADDR[1:0]};

   // Next-state and next-output decode.
   always_comb begin
      state_s   = state_r;
      prdata_s  = prdata_r;
      pready_s  = 1'b0;
      pslverr_s = pslverr_r;
      haddr_s   = haddr_r;
      htrans_s  = htrans_r;
      hwrite_s  = hwrite_r;
      hsize_s   = hsize_r;
      hprot_s   = hprot_r;
      hwdata_s  = hwdata_r;
      wdata_s   = wdata_r;
      abort_s   = abort_r;
      case (state_r)
         IDLE: begin
            if (PSEL && !PENABLE) begin
               abort_s = 1'b0;
               if (!PWRITE) begin
                  state_s  = ADDR;
                  htrans_s = HTRANS_NONSEQ;
                  haddr_s  = {PADDR[ADDRWIDTH-1:2], 2'b00};
                  hwrite_s = 1'b0;
                  hsize_s  = 3'b010;
                  hprot_s  = hprot_map_s;
               end else if (PSTRB == 4'b0000) begin
                  state_s   = DONE;
                  pready_s  = 1'b1;
                  pslverr_s = 1'b0;
               end else if (strb_dec_s[5]) begin
                  state_s  = ADDR;
                  htrans_s = HTRANS_NONSEQ;
                  haddr_s  = {PADDR[ADDRWIDTH-1:2], strb_dec_s[1:0]};
                  hwrite_s = 1'b1;
                  hsize_s  = strb_dec_s[4:2];
                  hprot_s  = hprot_map_s;
                  wdata_s  = PWDATA;
               end else begin
                  state_s   = DONE;
                  pready_s  = 1'b1;
                  pslverr_s = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         ADDR: begin
            abort_s = abort_r | ~PSEL;
            if (HREADY) begin
               state_s  = DATA;
               htrans_s = HTRANS_IDLE;
               if (hwrite_r) begin
                  hwdata_s = wdata_r;
               end else begin
                  hwdata_s = hwdata_r;
               end
            end else begin
               state_s = ADDR;
            end
         end
         DATA: begin
            abort_s = abort_r | ~PSEL;
            if (HREADY) begin
               // A requester that dropped PSEL gets no completion; the AHB side still finished.
               if (abort_s) begin
                  state_s = IDLE;
               end else begin
                  state_s   = DONE;
                  pready_s  = 1'b1;
                  pslverr_s = HRESP;
                  if (!hwrite_r) begin
                     prdata_s = HRDATA;
                  end else begin
                     prdata_s = prdata_r;
                  end
               end
            end else begin
               state_s = DATA;
            end
         end
         DONE: begin
            state_s   = IDLE;
            pslverr_s = 1'b0;
         end
         default: begin
            state_s  = IDLE;
            htrans_s = HTRANS_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_r     <= IDLE;
         prdata_r    <= {DATAWIDTH{1'b0}};
         pready_r    <= 1'b0;
         pslverr_r   <= 1'b0;
         haddr_r     <= {ADDRWIDTH{1'b0}};
         htrans_r    <= HTRANS_IDLE;
         hwrite_r    <= 1'b0;
         hsize_r     <= 3'b010;
         hprot_r     <= 4'b0011;
         hwdata_r    <= {DATAWIDTH{1'b0}};
         wdata_r     <= {DATAWIDTH{1'b0}};
         abort_r     <= 1'b0;
         apbactive_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         prdata_r    <= prdata_s;
         pready_r    <= pready_s;
         pslverr_r   <= pslverr_s;
         haddr_r     <= haddr_s;
         htrans_r    <= htrans_s;
         hwrite_r    <= hwrite_s;
         hsize_r     <= hsize_s;
         hprot_r     <= hprot_s;
         hwdata_r    <= hwdata_s;
         wdata_r     <= wdata_s;
         abort_r     <= abort_s;
         apbactive_r <= (state_s != IDLE);
      end
   end

   assign PRDATA    = prdata_r;
   assign PREADY    = pready_r;
   assign PSLVERR   = pslverr_r;
   assign HADDR     = haddr_r;
   assign HTRANS    = htrans_r;
   assign HWRITE    = hwrite_r;
   assign HSIZE     = hsize_r;
   assign HBURST    = 3'b000;
   assign HPROT     = hprot_r;
   assign HMASTLOCK = 1'b0;
   assign HWDATA    = hwdata_r;
   assign APBACTIVE = apbactive_r;

endmodule

// File: tb/tb_apb2ahb_bridge.sv
// Randomized scoreboard bench for apb2ahb_bridge: APB driver, AHB slave responder with
// its own memory, and an independent APB-level memory model predicting every completion.
module tb_apb2ahb_bridge;

   localparam logic [31:0] ERR_DATA = 32'hE0E0_E0E0;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b1;
   logic        PSEL, PENABLE, PWRITE;
   logic [15:0] PADDR;
   logic [31:0] PWDATA;
   logic [3:0]  PSTRB;
   logic [2:0]  PPROT;
   logic [31:0] PRDATA;
   logic        PREADY, PSLVERR;
   logic [15:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE, HBURST;
   logic [3:0]  HPROT;
   logic        HMASTLOCK;
   logic [31:0] HWDATA, HRDATA;
   logic        HREADY, HRESP;
   logic        APBACTIVE;

   always #5 HCLK = ~HCLK;

   apb2ahb_bridge #(.ADDRWIDTH(16), .DATAWIDTH(32)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
      .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .APBACTIVE(APBACTIVE)
   );

   typedef struct {
      logic [31:0] prdata;
      logic        pslverr;
   } apb_exp_t;

   typedef struct {
      int          aw;
      int          dw;
      bit          err;
      logic [15:0] haddr;
      logic [2:0]  hsize;
      logic        hwrite;
      logic [3:0]  hprot;
      logic [31:0] hwdata;
   } ahb_exp_t;

   apb_exp_t    sb_q[$];
   ahb_exp_t    ahb_q[$];
   logic [31:0] mem_model[int];
   logic [31:0] mem_ahb[int];
   logic [31:0] last_prdata = 32'h0;
   int          n_checks = 0;
   int          n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] model_rd(input int idx);
      return mem_model.exists(idx) ? mem_model[idx] : 32'h0;
   endfunction

   function automatic logic [31:0] ahb_rd(input int idx);
      return mem_ahb.exists(idx) ? mem_ahb[idx] : 32'h0;
   endfunction

   task automatic preload(input int idx, input logic [31:0] val);
      mem_model[idx] = val;
      mem_ahb[idx]   = val;
   endtask

   // Legal strobes are a naturally aligned run of 1, 2 or 4 bytes.
   function automatic void strb_info(input logic [3:0] s, output bit legal,
                                     output logic [2:0] size, output logic [1:0] low);
      int cnt;
      int lo;
      cnt = $countones(s);
      lo  = 0;
      for (int i = 3; i >= 0; i--) if (s[i]) lo = i;
      legal = (cnt == 1 || cnt == 2 || cnt == 4) &&
              (s == 4'(((1 << cnt) - 1) << lo)) && ((lo % cnt) == 0);
      size  = (cnt == 4) ? 3'b010 : (cnt == 2) ? 3'b001 : 3'b000;
      low   = 2'(lo);
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_prdata"},    PRDATA,    32'h0);
      chk({tag, "_pready"},    32'(PREADY),    32'h0);
      chk({tag, "_pslverr"},   32'(PSLVERR),   32'h0);
      chk({tag, "_haddr"},     32'(HADDR),     32'h0);
      chk({tag, "_htrans"},    32'(HTRANS),    32'h0);
      chk({tag, "_hwrite"},    32'(HWRITE),    32'h0);
      chk({tag, "_hsize"},     32'(HSIZE),     32'h2);
      chk({tag, "_hprot"},     32'(HPROT),     32'h3);
      chk({tag, "_hwdata"},    HWDATA,    32'h0);
      chk({tag, "_apbactive"}, 32'(APBACTIVE), 32'h0);
   endtask

   // Issues one APB access starting at a negedge; predicts AHB and APB results first.
   task automatic apb_xfer(input logic [15:0] addr, input bit wr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [2:0] prot,
                           input int aw, input int dw, input bit err, input bit drop_psel);
      bit          legal;
      bit          xfer;
      bit          saw;
      logic [2:0]  sz;
      logic [1:0]  lo;
      logic [31:0] w;
      int          exp_lat;
      int          n;
      int          idx;
      ahb_exp_t    a;
      apb_exp_t    e;
      idx = int'(addr[15:2]);
      strb_info(strb, legal, sz, lo);
      if (err && dw == 0) dw = 1;
      xfer = !wr || legal;
      if (xfer) begin
         a.aw = aw; a.dw = dw; a.err = err;
         a.haddr  = wr ? {addr[15:2], lo} : {addr[15:2], 2'b00};
         a.hsize  = wr ? sz : 3'b010;
         a.hwrite = wr;
         a.hprot  = {2'b00, prot[0], ~prot[2]};
         a.hwdata = wdata;
         ahb_q.push_back(a);
         exp_lat = 3 + aw + dw;
      end else begin
         exp_lat = 1;
      end
      if (!drop_psel) begin
         if (!wr) begin
            e.prdata  = err ? ERR_DATA : model_rd(idx);
            e.pslverr = err;
         end else begin
            e.prdata  = last_prdata;
            e.pslverr = (strb == 4'b0000) ? 1'b0 : (!legal ? 1'b1 : err);
         end
         last_prdata = e.prdata;
         sb_q.push_back(e);
      end
      if (wr && legal && !err) begin
         w = model_rd(idx);
         for (int i = 0; i < 4; i++) if (strb[i]) w[8*i +: 8] = wdata[8*i +: 8];
         mem_model[idx] = w;
      end
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr;
      PWDATA = wdata; PSTRB = strb; PPROT = prot;
      @(negedge HCLK);
      PENABLE = 1'b1;
      if (drop_psel) begin
         @(negedge HCLK);
         PSEL = 1'b0; PENABLE = 1'b0;
         saw = 1'b0;
         for (int k = 0; k < 30; k++) begin
            @(negedge HCLK);
            if (PREADY) saw = 1'b1;
            if (!APBACTIVE) break;
         end
         chk("abort_no_pready", 32'(saw), 32'h0);
         chk("abort_return_idle", 32'(APBACTIVE), 32'h0);
         @(negedge HCLK);
         return;
      end
      n = 1;
      while (!PREADY && n < 64) begin
         @(negedge HCLK);
         n++;
      end
      chk("pready_timeout", 32'(PREADY), 32'h1);
      chk("apb_latency", 32'(n), 32'(exp_lat));
      @(negedge HCLK);
      chk("pready_one_cycle", 32'(PREADY), 32'h0);
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   // AHB slave responder and address/data phase monitor.
   ahb_exp_t    sa;
   logic [15:0] cap_addr;
   logic [2:0]  cap_size;
   logic        cap_wr;
   logic [3:0]  lanes;
   logic [31:0] sw;
   initial begin
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
      forever begin
         @(negedge HCLK);
         if (HRESETn && HTRANS == 2'b10) begin
            if (ahb_q.size() == 0) begin
               chk("unexpected_nonseq", 32'h1, 32'h0);
               sa.aw = 0; sa.dw = 0; sa.err = 1'b0; sa.haddr = HADDR; sa.hsize = HSIZE;
               sa.hwrite = HWRITE; sa.hprot = HPROT; sa.hwdata = HWDATA;
            end else begin
               sa = ahb_q.pop_front();
            end
            chk("ahb_haddr", 32'(HADDR), 32'(sa.haddr));
            chk("ahb_hsize", 32'(HSIZE), 32'(sa.hsize));
            chk("ahb_hwrite", 32'(HWRITE), 32'(sa.hwrite));
            chk("ahb_hprot", 32'(HPROT), 32'(sa.hprot));
            chk("ahb_hburst", 32'(HBURST), 32'h0);
            chk("ahb_hmastlock", 32'(HMASTLOCK), 32'h0);
            cap_addr = HADDR; cap_size = HSIZE; cap_wr = HWRITE;
            for (int i = 0; i < sa.aw; i++) begin
               HREADY = 1'b0;
               @(negedge HCLK);
               chk("stall_htrans", 32'(HTRANS), 32'h2);
               chk("stall_haddr", 32'(HADDR), 32'(cap_addr));
               chk("stall_apbactive", 32'(APBACTIVE), 32'h1);
            end
            HREADY = 1'b1;
            @(negedge HCLK);
            chk("data_htrans_idle", 32'(HTRANS), 32'h0);
            if (cap_wr) chk("hwdata", HWDATA, sa.hwdata);
            for (int i = 0; i < sa.dw; i++) begin
               HREADY = 1'b0;
               HRESP  = sa.err && (i == sa.dw - 1);
               HRDATA = $urandom;
               @(negedge HCLK);
            end
            HREADY = 1'b1;
            HRESP  = sa.err;
            HRDATA = sa.err ? ERR_DATA : ahb_rd(int'(cap_addr[15:2]));
            if (cap_wr) begin
               chk("hwdata_hold", HWDATA, sa.hwdata);
               if (!sa.err) begin
                  case (cap_size)
                     3'b000:  lanes = 4'b0001 << cap_addr[1:0];
                     3'b001:  lanes = 4'b0011 << {cap_addr[1], 1'b0};
                     default: lanes = 4'b1111;
                  endcase
                  sw = ahb_rd(int'(cap_addr[15:2]));
                  for (int i = 0; i < 4; i++) if (lanes[i]) sw[8*i +: 8] = HWDATA[8*i +: 8];
                  mem_ahb[int'(cap_addr[15:2])] = sw;
               end
            end
            @(negedge HCLK);
            HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
         end
      end
   end

   // APB completion monitor: pops the scoreboard on every PREADY.
   apb_exp_t me;
   initial begin
      forever begin
         @(negedge HCLK);
         if (HRESETn && PREADY) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_pready", 32'h1, 32'h0);
            end else begin
               me = sb_q.pop_front();
               chk("prdata", PRDATA, me.prdata);
               chk("pslverr", 32'(PSLVERR), 32'(me.pslverr));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   ahb_exp_t    ra;
   logic [15:0] r_addr;
   logic [31:0] r_data;
   logic [3:0]  r_strb;
   bit          r_wr;
   bit          r_err;
   initial begin
      PSEL = 1'b0; PENABLE = 1'b0; PADDR = 16'h0; PWRITE = 1'b0;
      PWDATA = 32'h0; PSTRB = 4'h0; PPROT = 3'h0;
      #1 HRESETn = 1'b0;
      #2 chk_reset_vals("rst");
      @(negedge HCLK);
      @(negedge HCLK);
      HRESETn = 1'b1;
      @(negedge HCLK);

      preload(16'h1234 >> 2, 32'hDEADBEEF);
      apb_xfer(16'h1234, 1'b0, 32'h0, 4'h0, 3'b000, 0, 0, 1'b0, 1'b0);
      apb_xfer(16'h0042, 1'b1, 32'h00AB0000, 4'b0100, 3'b101, 0, 2, 1'b0, 1'b0);
      apb_xfer(16'h0040, 1'b0, 32'h0, 4'h0, 3'b011, 0, 0, 1'b0, 1'b0);
      apb_xfer(16'h0044, 1'b1, 32'h11223344, 4'b0101, 3'b000, 0, 0, 1'b0, 1'b0);
      apb_xfer(16'h0044, 1'b1, 32'h55667788, 4'b0000, 3'b000, 0, 0, 1'b0, 1'b0);
      apb_xfer(16'h0048, 1'b1, 32'hCAFEF00D, 4'b1111, 3'b001, 1, 0, 1'b0, 1'b0);
      apb_xfer(16'h0048, 1'b0, 32'h0, 4'h0, 3'b000, 0, 1, 1'b1, 1'b0);
      apb_xfer(16'h0048, 1'b0, 32'h0, 4'h0, 3'b000, 0, 0, 1'b0, 1'b0);
      apb_xfer(16'h004C, 1'b1, 32'h9ABC0000, 4'b1100, 3'b000, 0, 0, 1'b0, 1'b0);
      apb_xfer(16'h004C, 1'b0, 32'h0, 4'h0, 3'b100, 3, 0, 1'b0, 1'b0);
      apb_xfer(16'h0050, 1'b1, 32'h0BADC0DE, 4'b1111, 3'b000, 1, 1, 1'b0, 1'b1);
      apb_xfer(16'h0050, 1'b0, 32'h0, 4'h0, 3'b000, 0, 0, 1'b0, 1'b0);

      // Asynchronous reset during the data phase of a read.
      ra.aw = 0; ra.dw = 4; ra.err = 1'b0; ra.haddr = 16'h1234; ra.hsize = 3'b010;
      ra.hwrite = 1'b0; ra.hprot = 4'b0001; ra.hwdata = 32'h0;
      ahb_q.push_back(ra);
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = 16'h1234; PWRITE = 1'b0; PPROT = 3'b000;
      @(negedge HCLK);
      PENABLE = 1'b1;
      @(negedge HCLK);
      #2 HRESETn = 1'b0;
      #1 chk_reset_vals("midrst");
      PSEL = 1'b0; PENABLE = 1'b0;
      @(negedge HCLK);
      @(negedge HCLK);
      HRESETn = 1'b1;
      last_prdata = 32'h0;
      repeat (8) @(negedge HCLK);
      apb_xfer(16'h1234, 1'b0, 32'h0, 4'h0, 3'b000, 0, 0, 1'b0, 1'b0);

      for (int k = 0; k < 150; k++) begin
         r_addr = 16'($urandom_range(0, 255));
         r_wr   = 1'($urandom_range(0, 1));
         r_data = $urandom;
         r_strb = 4'($urandom_range(0, 15));
         r_err  = ($urandom_range(0, 7) == 0);
         apb_xfer(r_addr, r_wr, r_data, r_strb, 3'($urandom_range(0, 7)),
                  $urandom_range(0, 2), $urandom_range(0, 2), r_err, 1'b0);
         repeat ($urandom_range(0, 2)) @(negedge HCLK);
      end

      repeat (6) @(negedge HCLK);
      chk("sb_queue_empty", 32'(sb_q.size()), 32'h0);
      chk("ahb_queue_empty", 32'(ahb_q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
